hpdmc_wrdp: RTL and testbench
=============================

HPDMC_WRDP -- requirements
Module: hpdmc_wrdp

Interface
REQ-001 Parameter WR_LAT, default 2, meaning: sys_clk edges from accepted write command to first data beat (legal 2..7).
REQ-002 Parameter FIFO_AW, default 3, meaning: log2 of write-data FIFO depth in 32-bit words (default 8 words).
REQ-003 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wd_valid  in  1  host write-data word valid.
REQ-006 wd_data  in  32  word; [31:16] = rising beat, [15:0] = falling beat.
REQ-007 wd_mask  in  4  byte masks, 1 = masked; [3:2] rising, [1:0] falling.
REQ-008 wd_ready  out  1  FIFO can accept a word.
REQ-009 cmd_write  in  1  scheduler write-command strobe, one burst of 4 DDR beats (2 words).
REQ-010 cmd_ready  out  1  write command acceptable this cycle.
REQ-011 dq_d1, dq_d2  out  16 each  DQ data toward the same-edge output DDR register pair (D1 rising, D2 falling).
REQ-012 dm_d1, dm_d2  out  2 each  DM toward the output DDR registers.
REQ-013 dqs_d1, dqs_d2  out  2 each  DQS pattern toward the output DDR registers.
REQ-014 dq_oe, dqs_oe  out  1 each  tristate enables for DQ/DM and DQS pads.
REQ-015 busy  out  1  any burst pending or in progress.

Function
REQ-016 Word pushed into FIFO when wd_valid && wd_ready; wd_ready = FIFO not full, independent of a same-cycle pop.
REQ-017 Output state machine states: IDLE, LAT, PRE, BEAT0, BEAT1, POST; all outputs are registered.
REQ-018 Command accepted when cmd_write && cmd_ready; cmd_write with cmd_ready low is ignored with no state change.
REQ-019 cmd_ready = (state in IDLE, BEAT1, POST, or BEAT0 with no burst pending) && FIFO level >= 2 + 2*(accepted bursts whose words are not yet popped).
REQ-020 Accepted at edge k: outputs show BEAT0 after edge k+WR_LAT and BEAT1 after edge k+WR_LAT+1.
REQ-021 PRE shown after edge k+WR_LAT-1 unless that cycle is BEAT0/BEAT1 of the previous burst; LAT covers any remaining cycles between acceptance and PRE.
REQ-022 BEAT0/BEAT1 each pop one FIFO word: dq_d1/dq_d2 = word halves, dm_d1/dm_d2 = mask halves, dqs_d1 = 2'b11, dqs_d2 = 2'b00, dq_oe = dqs_oe = 1.
REQ-023 PRE: dqs_oe = 1, dqs_d1 = dqs_d2 = 0, dq_oe = 0, dm = 2'b11.
REQ-024 POST follows BEAT1 for one cycle (dqs_oe = 1, dqs = 0, dq_oe = 0) unless the next BEAT0 or PRE occupies it; then it returns to IDLE.
REQ-025 Contiguous bursts (BEAT1 directly followed by BEAT0) keep dq_oe and dqs_oe high with no PRE/POST.
REQ-026 Outside BEAT0/BEAT1: dq_d* hold 0 and dm_d* hold 2'b11.
REQ-027 busy = state != IDLE or a burst is pending.
REQ-028 FIFO pointers wrap modulo 2^FIFO_AW; level is tracked with one extra bit so full and empty are distinguishable.

Reset
REQ-029 While sys_rst_n = 0: state IDLE, FIFO empty, pending count 0, dq_d* = 0, dm_d* = 2'b11, dqs_d* = 0, dq_oe = dqs_oe = 0, busy = 0, cmd_ready = 0, wd_ready = 1.
REQ-030 Reset asserted mid-burst aborts it immediately (asynchronously) and discards buffered words; no partial beat is emitted after release.

Verification
REQ-031 Push 0xAAAA5555/mask 0x0, then 0x12345678/mask 0x4; write at edge k (WR_LAT = 2) -> PRE after k+1; after k+2 dq_d1 = AAAA, dq_d2 = 5555; after k+3 dq_d1 = 1234, dq_d2 = 5678, dm_d1 = 2'b01; POST after k+4; IDLE after k+5.
REQ-032 Four words queued, writes at edges k and k+2 -> beats occupy k+2..k+5 contiguously, dq_oe and dqs_oe never drop, single PRE and single POST.
REQ-033 One word in FIFO, cmd_write held high -> cmd_ready = 0, outputs stay IDLE values; after a second push, cmd_ready = 1 on the next cycle.
REQ-034 Push 9 words with no command (FIFO_AW = 3) -> wd_ready low after 8 pushes; 9th word dropped; level stays 8.
REQ-035 Drop sys_rst_n during BEAT0 -> dq_oe = dqs_oe = 0 and dm = 2'b11 immediately, wd_ready = 1, busy = 0.
REQ-036 WR_LAT = 5, write at edge k -> LAT for 3 cycles, PRE after k+4, BEAT0 after k+5.

Source files
------------

// File: rtl/hpdmc_wrdp.sv
// DDR write datapath: buffers host write words and replays them as PRE/BEAT0/BEAT1/POST
// bursts toward the output DDR register pairs a fixed WR_LAT edges after command acceptance.
module hpdmc_wrdp #(
  parameter int unsigned WR_LAT  = 2,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wd_valid,
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_mask,
  output logic        wd_ready,
  input  logic        cmd_write,
  output logic        cmd_ready,
  output logic [15:0] dq_d1,
  output logic [15:0] dq_d2,
  output logic [1:0]  dm_d1,
  output logic [1:0]  dm_d2,
  output logic [1:0]  dqs_d1,
  output logic [1:0]  dqs_d2,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned CW    = FIFO_AW + 2;
  localparam int unsigned SW    = WR_LAT;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LAT   = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_BEAT0 = 3'd3;
  localparam logic [2:0] S_BEAT1 = 3'd4;
  localparam logic [2:0] S_POST  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [SW-1:0] sched, sched_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, owed;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, owed_nxt, level_nxt;
  logic [35:0]   mem [DEPTH];
  logic [35:0]   rd_word;
  logic          push, accept, pop, pending, state_ok;
  logic [15:0]   dq_d1_nxt, dq_d2_nxt;
  logic [1:0]    dm_d1_nxt, dm_d2_nxt, dqs_d1_nxt, dqs_d2_nxt;
  logic          dq_oe_nxt, dqs_oe_nxt, busy_nxt, cmd_ready_nxt, wd_ready_nxt;

  // Word storage: {mask, data}; contents are don't-care until pushed.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {wd_mask, wd_data};
  end

  // Next state and registered-output values. sched[i] marks a burst accepted i+1 edges ago.
  always_comb begin
    state_nxt     = state;
    dq_d1_nxt     = '0;
    dq_d2_nxt     = '0;
    dm_d1_nxt     = 2'b11;
    dm_d2_nxt     = 2'b11;
    dqs_d1_nxt    = '0;
    dqs_d2_nxt    = '0;
    dq_oe_nxt     = 1'b0;
    dqs_oe_nxt    = 1'b0;
    push          = wd_valid && wd_ready;
    accept        = cmd_write && cmd_ready;
    pending       = |sched;
    rd_word       = mem[rd_ptr[FIFO_AW-1:0]];

    if (state == S_BEAT0)       state_nxt = S_BEAT1;
    else if (sched[SW-1])       state_nxt = S_BEAT0;
    else if (sched[SW-2])       state_nxt = S_PRE;
    else if (state == S_BEAT1)  state_nxt = S_POST;
    else if (pending)           state_nxt = S_LAT;
    else                        state_nxt = S_IDLE;

    pop = (state_nxt == S_BEAT0) || (state_nxt == S_BEAT1);

    case (state_nxt)
      S_BEAT0, S_BEAT1: begin
        dq_d1_nxt  = rd_word[31:16];
        dq_d2_nxt  = rd_word[15:0];
        dm_d1_nxt  = rd_word[35:34];
        dm_d2_nxt  = rd_word[33:32];
        dqs_d1_nxt = 2'b11;
        dq_oe_nxt  = 1'b1;
        dqs_oe_nxt = 1'b1;
      end
      S_PRE, S_POST: dqs_oe_nxt = 1'b1;
      default: ;
    endcase

    sched_nxt  = {sched[SW-2:0], accept};
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    owed_nxt   = owed + (accept ? PW'(2) : PW'(0)) - PW'(pop);

    // Blocking the edge right after an accept keeps successive BEAT0s at least two cycles apart.
    state_ok      = (state == S_IDLE) || (state == S_BEAT1) || (state == S_POST) ||
                    ((state == S_BEAT0) && !pending);
    cmd_ready_nxt = state_ok && !accept && (CW'(level_nxt) >= CW'(owed_nxt) + CW'(2));
    wd_ready_nxt  = level_nxt != PW'(DEPTH);
    busy_nxt      = (state_nxt != S_IDLE) || (|sched_nxt);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      sched     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      owed      <= '0;
      dq_d1     <= '0;
      dq_d2     <= '0;
      dm_d1     <= 2'b11;
      dm_d2     <= 2'b11;
      dqs_d1    <= '0;
      dqs_d2    <= '0;
      dq_oe     <= 1'b0;
      dqs_oe    <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      wd_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      sched     <= sched_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      owed      <= owed_nxt;
      dq_d1     <= dq_d1_nxt;
      dq_d2     <= dq_d2_nxt;
      dm_d1     <= dm_d1_nxt;
      dm_d2     <= dm_d2_nxt;
      dqs_d1    <= dqs_d1_nxt;
      dqs_d2    <= dqs_d2_nxt;
      dq_oe     <= dq_oe_nxt;
      dqs_oe    <= dqs_oe_nxt;
      busy      <= busy_nxt;
      cmd_ready <= cmd_ready_nxt;
      wd_ready  <= wd_ready_nxt;
    end
  end

endmodule

// File: tb/tb_hpdmc_wrdp.sv
// Bench for hpdmc_wrdp: scoreboard of pushed words against emitted beats plus directed timing checks.
module tb_hpdmc_wrdp;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wd_valid, wd_ready, cmd_write, cmd_ready, dq_oe, dqs_oe, busy;
  logic [31:0] wd_data;
  logic [3:0]  wd_mask;
  logic [15:0] dq_d1, dq_d2;
  logic [1:0]  dm_d1, dm_d2, dqs_d1, dqs_d2;

  logic        w5_valid, w5_ready, c5_write, c5_ready, dq5_oe, dqs5_oe, busy5;
  logic [31:0] w5_data;
  logic [15:0] dq5_d1, dq5_d2;
  logic [1:0]  dm5_d1, dm5_d2, dqs5_d1, dqs5_d2;

  int n_chk = 0;
  int n_pass = 0;
  logic [35:0] mq[$];
  logic [35:0] exp_q[$];
  logic [35:0] sb_e;

  always #5 sys_clk = ~sys_clk;

  hpdmc_wrdp dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_mask(wd_mask), .wd_ready(wd_ready),
    .cmd_write(cmd_write), .cmd_ready(cmd_ready),
    .dq_d1(dq_d1), .dq_d2(dq_d2), .dm_d1(dm_d1), .dm_d2(dm_d2),
    .dqs_d1(dqs_d1), .dqs_d2(dqs_d2), .dq_oe(dq_oe), .dqs_oe(dqs_oe), .busy(busy)
  );

  hpdmc_wrdp #(.WR_LAT(5), .FIFO_AW(3)) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wd_valid(w5_valid), .wd_data(w5_data), .wd_mask(4'h0), .wd_ready(w5_ready),
    .cmd_write(c5_write), .cmd_ready(c5_ready),
    .dq_d1(dq5_d1), .dq_d2(dq5_d2), .dm_d1(dm5_d1), .dm_d2(dm5_d2),
    .dqs_d1(dqs5_d1), .dqs_d2(dqs5_d2), .dq_oe(dq5_oe), .dqs_oe(dqs5_oe), .busy(busy5)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Model: track accepted words; an accepted command claims the two oldest.
  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      if (wd_valid && wd_ready) mq.push_back({wd_mask, wd_data});
      if (cmd_write && cmd_ready) begin
        if (mq.size() < 2) check("cmd_underflow", 64'(mq.size()), 64'd2);
        else begin
          exp_q.push_back(mq.pop_front());
          exp_q.push_back(mq.pop_front());
        end
      end
    end
  end

  // Every data beat must match the next expected word.
  always @(negedge sys_clk) begin
    if (sys_rst_n && dq_oe) begin
      if (exp_q.size() == 0) check("beat_unexpected", 64'd1, 64'd0);
      else begin
        sb_e = exp_q.pop_front();
        check("beat_dq", {dq_d1, dq_d2}, 64'(sb_e[31:0]));
        check("beat_dm", {dm_d1, dm_d2}, 64'(sb_e[35:32]));
        check("beat_dqs", {dqs_d1, dqs_d2, dqs_oe}, 64'b11001);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    wd_valid = 1'b1;
    wd_data  = d;
    wd_mask  = m;
    step();
    wd_valid = 1'b0;
  endtask

  task automatic issue_write();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) check("cmd_timeout", 64'd0, 64'd1);
    else begin
      cmd_write = 1'b1;
      step();
      cmd_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v_dqs, v_dq;
    logic [8:0] v5_dqs, v5_dq, v5_busy;
    wd_valid = 0; wd_data = '0; wd_mask = '0; cmd_write = 0;
    w5_valid = 0; w5_data = '0; c5_write = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_wd_ready", wd_ready, 1);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", {dq_oe, dqs_oe}, 0);
    check("rst_dm", {dm_d1, dm_d2}, 4'hf);
    check("rst_dq_dqs", {dq_d1, dq_d2, dqs_d1, dqs_d2}, 0);
    sys_rst_n = 1'b1;
    step();
    step();

    // Single burst, WR_LAT = 2
    push(32'hAAAA5555, 4'h0);
    push(32'h12345678, 4'h4);
    check("t1_cmd_ready", cmd_ready, 1);
    cmd_write = 1'b1;
    step();
    cmd_write = 1'b0;
    check("t1_k_busy", busy, 1);
    check("t1_k_dqs_oe", dqs_oe, 0);
    step();
    check("t1_pre", {dqs_oe, dq_oe, dm_d1, dm_d2, dqs_d1, dqs_d2}, 10'b10_1111_0000);
    step();
    check("t1_beat0", {dq_d1, dq_d2}, 32'hAAAA5555);
    step();
    check("t1_beat1", {dq_d1, dq_d2, dm_d1}, {32'h12345678, 2'b01});
    step();
    check("t1_post", {dqs_oe, dq_oe, dqs_d1, dqs_d2, dm_d1, dm_d2}, 10'b10_0000_1111);
    step();
    check("t1_idle", {dqs_oe, busy}, 0);

    // Two contiguous bursts
    for (int i = 0; i < 4; i++) push($urandom, 4'($urandom));
    v_dqs = '0;
    v_dq  = '0;
    for (int i = 0; i < 8; i++) begin
      cmd_write = (i == 0) || (i == 2);
      step();
      cmd_write = 1'b0;
      v_dqs = {v_dqs[6:0], dqs_oe};
      v_dq  = {v_dq[6:0], dq_oe};
    end
    check("t2_dqs_oe", v_dqs, 8'b01111110);
    check("t2_dq_oe", v_dq, 8'b00111100);
    check("t2_busy_end", busy, 0);

    // Not enough data: command held off until a second word arrives
    push(32'h0BAD_F00D, 4'h2);
    cmd_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_ready", cmd_ready, 0);
      check("t3_hold_idle", {dqs_oe, dq_oe}, 0);
    end
    push(32'h600D_CAFE, 4'h8);
    check("t3_ready_after_push", cmd_ready, 1);
    step();
    cmd_write = 1'b0;
    repeat (6) step();
    check("t3_busy_end", busy, 0);

    // FIFO full: ninth word dropped
    for (int i = 0; i < 9; i++) begin
      check("t4_wd_ready", wd_ready, 64'(i < 8));
      push(32'h1000_0000 + 32'(i), 4'(i));
    end
    check("t4_full", wd_ready, 0);
    for (int i = 0; i < 4; i++) issue_write();
    repeat (8) step();
    check("t4_drained", 64'(exp_q.size()), 0);
    check("t4_cmd_ready_empty", cmd_ready, 0);
    check("t4_wd_ready_empty", wd_ready, 1);
    check("t4_busy", busy, 0);

    // Reset during BEAT0
    push(32'hDEAD_BEEF, 4'h0);
    push(32'hFEED_FACE, 4'h0);
    issue_write();
    step();
    step();
    check("t5_in_beat0", dq_oe, 1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_oe", {dq_oe, dqs_oe}, 0);
    check("t5_rst_dm", {dm_d1, dm_d2}, 4'hf);
    check("t5_rst_wd_ready", wd_ready, 1);
    check("t5_rst_busy", busy, 0);
    exp_q.delete();
    mq.delete();
    step();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_beat", {dq_oe, dqs_oe, busy}, 0);
    end

    // WR_LAT = 5 instance: three LAT cycles then PRE, BEAT0, BEAT1, POST
    w5_valid = 1'b1;
    w5_data  = 32'hCAFE_F00D;
    step();
    w5_data  = 32'h0123_4567;
    step();
    w5_valid = 1'b0;
    check("t6_cmd_ready", c5_ready, 1);
    v5_dqs = '0;
    v5_dq = '0;
    v5_busy = '0;
    for (int i = 0; i < 9; i++) begin
      c5_write = (i == 0);
      step();
      c5_write = 1'b0;
      v5_dqs  = {v5_dqs[7:0], dqs5_oe};
      v5_dq   = {v5_dq[7:0], dq5_oe};
      v5_busy = {v5_busy[7:0], busy5};
      if (i == 5) check("t6_beat0_data", {dq5_d1, dq5_d2}, 32'hCAFE_F00D);
      if (i == 6) check("t6_beat1_data", {dq5_d1, dq5_d2}, 32'h0123_4567);
    end
    check("t6_dqs_oe", v5_dqs, 9'b000011110);
    check("t6_dq_oe", v5_dq, 9'b000001100);
    check("t6_busy", v5_busy, 9'b111111110);

    check("end_sb_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
